priority_data_stage: RTL
========================

PRIORITY_DATA_STAGE -- requirements
Module: priority_data_stage

Interface
REQ-001 SHALL have parameter: DATA_W, default 8, channel data width.
REQ-002 SHALL have parameter: CNT_W, default 8, width of each statistics counter.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports: s1, s0  input  1 each  encoder select; channel index = {s1,s0}.
REQ-006 SHALL have port: valid  input  1  encoder valid; a request exists this cycle.
REQ-007 SHALL have ports: d0, d1, d2, d3  input  DATA_W each  channel data.
REQ-008 SHALL have port: in_ready  output  1  stage can accept the current request.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the output this cycle.
REQ-010 SHALL have port: out_valid  output  1  registered result present.
REQ-011 SHALL have port: out_data  output  DATA_W  processed result.
REQ-012 SHALL have port: out_ch  output  2  channel index of out_data.
REQ-013 SHALL have ports (STATS_EN only): cnt0..cnt3  output  CNT_W each  per-channel accepted counts; drop_cnt  output  CNT_W  refused requests.

Function
REQ-014 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL drive in_ready = !out_valid | out_ready, combinationally.
REQ-016 SHALL accept a request when valid & in_ready.
REQ-017 SHALL register out_data, out_ch and out_valid=1 on the edge after acceptance (latency 1 cycle).
REQ-018 SHALL compute out_data by channel: ch0 passes d0; ch1 gives d1+1 modulo 2^DATA_W; ch2 gives ~d2; ch3 gives d3<<1 with LSB 0 and MSB discarded.
REQ-019 SHALL stay in EMPTY on valid=0 in EMPTY.
REQ-020 SHALL move from EMPTY to FULL on acceptance.
REQ-021 SHALL stay in FULL and load new data when out_ready=1 and valid=1 (back-to-back, one transfer per cycle).
REQ-022 SHALL move from FULL to EMPTY when out_ready=1 and valid=0.
REQ-023 SHALL hold out_data and out_ch stable while out_valid=1 and out_ready=0.
REQ-024 SHALL not alter state on refused requests (valid=1, in_ready=0); a request is not stored for later.
REQ-025 SHALL ignore s1, s0 and d0..d3 when valid=0.

Reset
REQ-026 SHALL on rst=1 at a clock edge clear out_valid=0, out_data=0, out_ch=0 and all counters to 0, enter EMPTY, and take priority over any simultaneous acceptance.
REQ-027 SHALL discard a held output on reset mid-operation with no transfer; in_ready=1 in the first cycle after reset.

Configuration
REQ-028 SHALL have macro: PRIORITY_DATA_STATS_EN.
REQ-029 SHALL, with the macro defined, increment cnt{ch} by 1 on each acceptance and increment drop_cnt on each refused request, each saturating at 2^CNT_W-1.
REQ-030 SHALL, without the macro defined, omit cnt0..cnt3, drop_cnt and their logic from the port list and the design, with no other change in behaviour.

Verification
REQ-031 SHALL verify: rst=1 for 2 cycles, then release -> out_valid=0, out_data=0x00, out_ch=0, in_ready=1, counters 0.
REQ-032 SHALL verify: valid=1, {s1,s0}=01, d1=0xFF, out_ready=1 -> next cycle out_valid=1, out_data=0x00, out_ch=1.
REQ-033 SHALL verify: {s1,s0}=11, d3=0x81 accepted, then out_ready=0 for 3 cycles while {s1,s0}=10, d2=0x0F is presented -> out_data stays 0x02, out_ch=3, in_ready=0, drop_cnt=3.
REQ-034 SHALL verify: out_ready=1 and valid=1 every cycle with ch0 d0=0x10, 0x11, 0x12 -> out_data 0x10, 0x11, 0x12 on consecutive cycles, cnt0=3.
REQ-035 SHALL verify: {s1,s0}=10, d2=0xA5 accepted with out_ready=0, then rst=1 for one cycle -> out_valid=0 next cycle, out_data=0x00, no transfer.
REQ-036 SHALL verify, with STATS_EN and CNT_W=2: 5 ch0 acceptances -> cnt0=3 (saturated).

Source files
------------

// File: rtl/priority_data_stage.sv
// priority_data_stage: 4-channel select-and-process stage with a
// one-entry registered output and valid/ready handshake.
// Optional per-channel statistics counters: define PRIORITY_DATA_STATS_EN.
module priority_data_stage #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s1,
  input  logic              s0,
  input  logic              valid,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_ch
`ifdef PRIORITY_DATA_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  state_t            state;
  logic [1:0]        sel;
  logic              accept;
  logic [DATA_W-1:0] result;

  assign sel      = {s1, s0};
  assign in_ready = !out_valid | out_ready;
  assign accept   = valid & in_ready;

  // Per-channel processing of the selected input word
  always_comb begin
    result = '0;
    unique case (sel)
      2'd0: result = d0;
      2'd1: result = d1 + DATA_ONE;
      2'd2: result = ~d2;
      2'd3: result = {d3[DATA_W-2:0], 1'b0};
      default: result = '0;
    endcase
  end

  // Output register FSM: EMPTY holds nothing, FULL presents one result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= result;
            out_ch    <= sel;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (valid) begin
              out_data <= result;
              out_ch   <= sel;
            end else begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PRIORITY_DATA_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W-1:0] drops;
  logic             refuse;

  assign refuse = valid & ~in_ready;

  // Saturating acceptance counters per channel and refused-request counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
      drops <= '0;
    end else begin
      if (accept && (cnt[sel] != '1)) cnt[sel] <= cnt[sel] + CNT_ONE;
      if (refuse && (drops != '1))    drops    <= drops + CNT_ONE;
    end
  end

  assign cnt0     = cnt[0];
  assign cnt1     = cnt[1];
  assign cnt2     = cnt[2];
  assign cnt3     = cnt[3];
  assign drop_cnt = drops;
`endif

endmodule
